// File: rtl/bdc_clk_pulse_generator.sv
// Fractional-rate BDC clock strobe generator: a phase accumulator adds DIV per system
// clock and wraps modulo the measured SYNC length, emitting one registered tick per wrap.
module bdc_clk_pulse_generator #(
  parameter int DIV       = 128,
  parameter int LEN_WIDTH = 32,
  parameter int ACC_WIDTH = 33
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LEN_WIDTH-1:0] sync_length,
  input  logic                 set_sync_length,
  output logic                 bdc_clk_pulse
);

  localparam logic [ACC_WIDTH-1:0] C_DIV_ACC = ACC_WIDTH'(DIV);
  localparam logic [LEN_WIDTH-1:0] C_DIV_LEN = LEN_WIDTH'(DIV);

  logic [LEN_WIDTH-1:0] r_sync_len;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_pulse;

  logic [ACC_WIDTH-1:0] w_len_ext;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [ACC_WIDTH-1:0] w_wrapped;
  logic                 w_idle;
  logic                 w_sat;
  logic                 w_hit;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic                 w_pulse_next;

  assign w_len_ext = ACC_WIDTH'(r_sync_len);
  assign w_sum     = r_acc + C_DIV_ACC;
  assign w_wrapped = w_sum - w_len_ext;
  assign w_idle    = (r_sync_len == '0);
  // Lengths up to DIV would need more than one tick per clock; clamp to every cycle.
  assign w_sat     = !w_idle && (r_sync_len <= C_DIV_LEN);
  assign w_hit     = (w_sum >= w_len_ext);

  always_comb begin
    w_acc_next   = '0;
    w_pulse_next = 1'b0;
    if (w_idle) begin
      w_acc_next   = '0;
      w_pulse_next = 1'b0;
    end else if (w_sat) begin
      w_acc_next   = '0;
      w_pulse_next = 1'b1;
    end else if (w_hit) begin
      w_acc_next   = w_wrapped;
      w_pulse_next = 1'b1;
    end else begin
      w_acc_next   = w_sum;
      w_pulse_next = 1'b0;
    end
  end

  // set_sync_length is a one-cycle strobe with no back-pressure; it restarts the phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync_len <= '0;
      r_acc      <= '0;
      r_pulse    <= 1'b0;
    end else if (set_sync_length) begin
      r_sync_len <= sync_length;
      r_acc      <= '0;
      r_pulse    <= 1'b0;
    end else begin
      r_acc      <= w_acc_next;
      r_pulse    <= w_pulse_next;
    end
  end

  assign bdc_clk_pulse = r_pulse;

endmodule

// File: tb/tb_bdc_clk_pulse_generator.sv
// Directed bench for bdc_clk_pulse_generator; expected ticks come from the ideal
// floor(DIV*k/len) phase model counted from the load edge.
module tb_bdc_clk_pulse_generator;

  logic        clk;
  logic        rst;
  logic [31:0] sync_length;
  logic        set_sync_length;
  logic        bdc_clk_pulse;

  int n_checks;
  int n_fail;

  bdc_clk_pulse_generator #(
    .DIV(128), .LEN_WIDTH(32), .ACC_WIDTH(33)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sync_length     (sync_length),
    .set_sync_length (set_sync_length),
    .bdc_clk_pulse   (bdc_clk_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal tick at edge k after load: the count of whole BDC clocks increases.
  function automatic logic exp_pulse(input longint len, input longint k);
    if (len == 0) return 1'b0;
    return ((128 * k) / len) != ((128 * (k - 1)) / len);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] len);
    sync_length     = len;
    set_sync_length = 1'b1;
    tick();
    set_sync_length = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b0;
    set_sync_length = 1'b0;
    tick();
    n_checks++;
    if (bdc_clk_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulse: got %b want 0", bdc_clk_pulse);
    end
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bdc_clk_pulse !== 1'b0) cnt++;
    end
    n_checks++;
    if (cnt != 0) begin
      n_fail++;
      $display("FAIL reset_idle: got %0d pulses want 0", cnt);
    end
  endtask

  task automatic test_nominal();
    int cnt;
    int last;
    int bad_iv;
    int pos[3];
    load(32'd1475);
    n_checks++;
    if (bdc_clk_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_load_edge: got %b want 0", bdc_clk_pulse);
    end
    cnt = 0; last = 0; bad_iv = 0;
    for (int k = 1; k <= 1475; k++) begin
      tick();
      if (k == 5) sync_length = 32'd100;
      n_checks++;
      if (bdc_clk_pulse !== exp_pulse(1475, k)) begin
        n_fail++;
        $display("FAIL nominal_edge%0d: got %b want %b", k, bdc_clk_pulse, exp_pulse(1475, k));
      end
      if (bdc_clk_pulse === 1'b1) begin
        if (cnt < 3) pos[cnt] = k;
        if ((k - last) < 11 || (k - last) > 12) bad_iv++;
        last = k;
        cnt++;
      end
    end
    n_checks++;
    if (cnt != 128) begin
      n_fail++;
      $display("FAIL nominal_count: got %0d want 128", cnt);
    end
    n_checks++;
    if (bad_iv != 0) begin
      n_fail++;
      $display("FAIL nominal_interval: got %0d bad intervals want 0", bad_iv);
    end
    n_checks++;
    if (cnt < 3 || pos[0] != 12 || pos[1] != 24 || pos[2] != 35) begin
      n_fail++;
      $display("FAIL nominal_first_ticks: got %0d,%0d,%0d want 12,24,35", pos[0], pos[1], pos[2]);
    end
    n_checks++;
    if (last != 1475) begin
      n_fail++;
      $display("FAIL nominal_no_drift: got last tick %0d want 1475", last);
    end
  endtask

  task automatic test_integer_ratio();
    int bad;
    load(32'd1280);
    bad = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (bdc_clk_pulse !== ((k % 10) == 0)) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL integer_ratio: got %0d wrong edges want 0", bad);
    end
  endtask

  task automatic test_saturation();
    int lens[3];
    lens[0] = 100; lens[1] = 128; lens[2] = 0;
    for (int i = 0; i < 3; i++) begin
      int bad;
      load(lens[i]);
      n_checks++;
      if (bdc_clk_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_load_edge_len%0d: got %b want 0", lens[i], bdc_clk_pulse);
      end
      bad = 0;
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (bdc_clk_pulse !== (lens[i] != 0)) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL sat_len%0d: got %0d wrong edges want 0", lens[i], bad);
      end
    end
  endtask

  task automatic test_reload();
    int bad;
    load(32'd1475);
    for (int k = 1; k <= 34; k++) tick();
    // Edge 35 would have ticked; the reload must suppress it.
    load(32'd2560);
    n_checks++;
    if (bdc_clk_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_edge: got %b want 0", bdc_clk_pulse);
    end
    bad = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (bdc_clk_pulse !== exp_pulse(2560, k)) bad++;
      if (k == 20) begin
        n_checks++;
        if (bdc_clk_pulse !== 1'b1) begin
          n_fail++;
          $display("FAIL reload_first_tick: got %b want 1", bdc_clk_pulse);
        end
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reload_period20: got %0d wrong edges want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    load(32'd1475);
    for (int k = 1; k <= 11; k++) tick();
    load(32'd1475);
    n_checks++;
    if (bdc_clk_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL same_reload_edge: got %b want 0", bdc_clk_pulse);
    end
    bad = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bdc_clk_pulse !== exp_pulse(1475, k)) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL same_reload_phase: got %0d wrong edges want 0", bad);
    end
  endtask

  task automatic test_reset_midrun();
    int cnt;
    load(32'd1475);
    for (int k = 1; k <= 11; k++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++;
    if (bdc_clk_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset_edge: got %b want 0", bdc_clk_pulse);
    end
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (bdc_clk_pulse !== 1'b0) cnt++;
    end
    n_checks++;
    if (cnt != 0) begin
      n_fail++;
      $display("FAIL midrun_reset_idle: got %0d pulses want 0", cnt);
    end
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b0;
    sync_length     = '0;
    set_sync_length = 1'b0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_integer_ratio();
    test_saturation();
    test_reload();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
